// File: rtl/alu_pkg.sv
// Shared encodings for the iterative ALU: block select, funct3 codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   // alu_control[4:3] block select
   localparam logic [1:0] BLOCK0 = 2'd0;   // add/logic/shift
   localparam logic [1:0] BLOCK1 = 2'd1;   // sub / arithmetic shift
   localparam logic [1:0] BLOCK2 = 2'd2;   // branch compare
   localparam logic [1:0] BLOCK3 = 2'd3;   // pass operand_a

   // Base ALU funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_SUB  = 3'b000;
   localparam logic [2:0] F3_SRA  = 3'b101;

   // Branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // M-extension funct3
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

   // Operand signedness for M ops. MUL keeps both unsigned: the low half
   // of the product is identical either way.
   function automatic logic m_a_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic m_b_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) on magnitudes.
// Latency: start cycle performs iteration 1, done registered after XLEN iterations.
// Backpressure: none; result stays valid until the next start, flush aborts.
// Ports: start/op/abs_a/abs_b/sign_a/sign_b in; done and sign-corrected result out.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] abs_a,
   input  logic [XLEN-1:0] abs_b,
   input  logic            sign_a,
   input  logic            sign_b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int SHW   = $clog2(XLEN);
   localparam int CNT_W = SHW + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

   // hi: product upper half / partial remainder; lo: multiplier / quotient
   logic [XLEN-1:0]  hi, lo, b_q;
   logic [2:0]       op_q;
   logic             sa_q, sb_q, busy;
   logic [CNT_W-1:0] cnt;

   logic [XLEN-1:0]  cur_hi, cur_lo, cur_b, nxt_hi, nxt_lo, sub;
   logic             cur_div, ge;
   logic [XLEN:0]    sum, shifted;

   // One iteration; on start it runs directly on the fresh operands so the
   // load cycle is not wasted.
   always_comb begin
      cur_hi  = start ? '0    : hi;
      cur_lo  = start ? abs_a : lo;
      cur_b   = start ? abs_b : b_q;
      cur_div = start ? op[2] : op_q[2];
      sum     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
      shifted = {cur_hi, cur_lo[XLEN-1]};
      ge      = shifted >= {1'b0, cur_b};
      // remainder after a successful subtract is below the divisor, so it fits XLEN bits
      sub     = shifted[XLEN-1:0] - cur_b;
      if (cur_div) begin
         nxt_hi = ge ? sub : shifted[XLEN-1:0];
         nxt_lo = {cur_lo[XLEN-2:0], ge};
      end else begin
         nxt_hi = sum[XLEN:1];
         nxt_lo = {sum[0], cur_lo[XLEN-1:1]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi   <= '0;
         lo   <= '0;
         b_q  <= '0;
         op_q <= '0;
         sa_q <= 1'b0;
         sb_q <= 1'b0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (flush) begin
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         hi   <= nxt_hi;
         lo   <= nxt_lo;
         b_q  <= abs_b;
         op_q <= op;
         sa_q <= sign_a;
         sb_q <= sign_b;
         cnt  <= CNT_W'(1);
         busy <= 1'b1;
         done <= 1'b0;
      end else if (busy) begin
         hi  <= nxt_hi;
         lo  <= nxt_lo;
         cnt <= cnt + CNT_W'(1);
         if (cnt == LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

   // Sign correction: product/quotient negative when signs differ,
   // remainder takes the dividend's sign.
   logic [2*XLEN-1:0] prod, prod_c;
   logic [XLEN-1:0]   quo_c, rem_c;

   always_comb begin
      prod   = {hi, lo};
      prod_c = (sa_q ^ sb_q) ? -prod : prod;
      quo_c  = (sa_q ^ sb_q) ? -lo : lo;
      rem_c  = sa_q ? -hi : hi;
      case (op_q)
         F3_MUL:                  result = prod_c[XLEN-1:0];
         F3_MULH, F3_MULHSU,
         F3_MULHU:                result = prod_c[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:         result = quo_c;
         default:                 result = rem_c;
      endcase
   end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle base ops plus iterative RV32M/RV64M mul/div.
// Latency: base 1 cycle; M ops XLEN+2 cycles; div-by-zero/overflow 2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
// Ports: clock/reset/flush; in_valid/in_ready, alu_control, operand_a/b in;
//        out_valid/out_ready, alu_result, branch out.
module alu_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      alu_control,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_result,
   output logic            branch
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   logic [XLEN-1:0] a_q, b_q;
   logic [2:0]      f3_q;
   logic            accept;

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   // ---------------- base ops ----------------
   logic [XLEN-1:0] base_res;
   logic            base_br, cmp;
   logic [SHW-1:0]  shamt;
   logic [2:0]      f3;

   always_comb begin
      f3       = alu_control[2:0];
      shamt    = operand_b[SHW-1:0];
      base_res = '0;
      base_br  = 1'b0;
      cmp      = 1'b0;
      case (alu_control[4:3])
         BLOCK0: begin
            case (f3)
               F3_ADD:  base_res = operand_a + operand_b;
               F3_SLL:  base_res = operand_a << shamt;
               F3_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
               F3_SLTU: base_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
               F3_XOR:  base_res = operand_a ^ operand_b;
               F3_SRL:  base_res = operand_a >> shamt;
               F3_OR:   base_res = operand_a | operand_b;
               default: base_res = operand_a & operand_b;
            endcase
         end
         BLOCK1: begin
            if (f3 == F3_SUB)
               base_res = operand_a - operand_b;
            else if (f3 == F3_SRA)
               base_res = $unsigned($signed(operand_a) >>> shamt);
         end
         BLOCK2: begin
            case (f3)
               F3_BEQ:  cmp = operand_a == operand_b;
               F3_BNE:  cmp = operand_a != operand_b;
               F3_BLT:  cmp = $signed(operand_a) < $signed(operand_b);
               F3_BGE:  cmp = $signed(operand_a) >= $signed(operand_b);
               F3_BLTU: cmp = operand_a < operand_b;
               F3_BGEU: cmp = operand_a >= operand_b;
               default: cmp = 1'b0;
            endcase
            base_res = {{(XLEN-1){1'b0}}, cmp};
            base_br  = cmp;
         end
         default: base_res = operand_a;
      endcase
   end

   // ---------------- PREP: signs, magnitudes, special cases ----------------
   logic            sgn_a, sgn_b, div0, ovf, special, md_start, md_done;
   logic [XLEN-1:0] abs_a, abs_b, special_res, md_result;

   always_comb begin
      sgn_a   = m_a_signed(f3_q) && a_q[XLEN-1];
      sgn_b   = m_b_signed(f3_q) && b_q[XLEN-1];
      abs_a   = sgn_a ? -a_q : a_q;
      abs_b   = sgn_b ? -b_q : b_q;
      div0    = f3_q[2] && (b_q == '0);
      ovf     = (f3_q == F3_DIV || f3_q == F3_REM) && (a_q == XMIN) && (b_q == '1);
      special = div0 || ovf;
      // f3_q[1] distinguishes REM/REMU from DIV/DIVU
      if (div0)
         special_res = f3_q[1] ? a_q : '1;
      else
         special_res = f3_q[1] ? '0 : XMIN;
   end

   assign md_start = (state == PREP) && !special && !flush;

   alu_muldiv_seq #(.XLEN(XLEN)) u_muldiv (
      .clock  (clock),
      .reset  (reset),
      .flush  (flush),
      .start  (md_start),
      .op     (f3_q),
      .abs_a  (abs_a),
      .abs_b  (abs_b),
      .sign_a (sgn_a),
      .sign_b (sgn_b),
      .done   (md_done),
      .result (md_result)
   );

   // ---------------- FSM with registered outputs ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         alu_result <= '0;
         branch     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         f3_q       <= '0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (state == DONE && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
               // a new accept in the same cycle overrides the drain to IDLE
               if (accept) begin
                  if (!alu_control[5]) begin
                     alu_result <= base_res;
                     branch     <= base_br;
                     out_valid  <= 1'b1;
                     state      <= DONE;
                  end else begin
                     a_q       <= operand_a;
                     b_q       <= operand_b;
                     f3_q      <= alu_control[2:0];
                     branch    <= 1'b0;
                     out_valid <= 1'b0;
                     state     <= PREP;
                  end
               end
            end
            PREP: begin
               if (special) begin
                  alu_result <= special_res;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               if (md_done) begin
                  alu_result <= md_result;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid, branch;
   logic [5:0]  alu_control;
   logic [31:0] operand_a, operand_b, alu_result;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   alu_iter #(.XLEN(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_result  (alu_result),
      .branch      (branch)
   );

   typedef struct {
      string       name;
      logic [5:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        br;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic [5:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] r, input logic br,
                               input int lat);
      vec_t v;
      v.name = n; v.ctl = c; v.a = a; v.b = b; v.res = r; v.br = br; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Called at a negedge with out_ready=1; returns at the negedge where out_valid rose.
   task automatic run_vec(input vec_t v);
      int   c;
      logic busy_ok;
      alu_control = v.ctl;
      operand_a   = v.a;
      operand_b   = v.b;
      in_valid    = 1'b1;
      chk($sformatf("%s in_ready", v.name), in_ready, 1);
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      operand_a = ~v.a;
      operand_b = ~v.b;
      c = 0;
      busy_ok = 1'b1;
      do begin
         @(negedge clock);
         c++;
         if (!out_valid && in_ready) busy_ok = 1'b0;
      end while (!out_valid && c < 100);
      chk($sformatf("%s latency", v.name), c, v.lat);
      chk($sformatf("%s result", v.name), alu_result, v.res);
      chk($sformatf("%s branch", v.name), branch, v.br);
      if (v.lat > 1) chk($sformatf("%s in_ready low while busy", v.name), busy_ok, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c;
      logic stray;

      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_control = '0; operand_a = '0; operand_b = '0;

      // ---- reset state ----
      #1 reset = 1'b1;
      #3;
      chk("reset out_valid", out_valid, 0);
      chk("reset alu_result", alu_result, 0);
      chk("reset branch", branch, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1 chk("in_ready after reset", in_ready, 1);
      @(negedge clock);

      // ---- directed vectors ----
      vecs.push_back(mk("ADD",      6'h00, 32'h5,        32'hFFFFFFFD, 32'h2,        0, 1));
      vecs.push_back(mk("SUB",      6'h08, 32'h5,        32'h7,        32'hFFFFFFFE, 0, 1));
      vecs.push_back(mk("SLL",      6'h01, 32'h1,        32'h21,       32'h2,        0, 1));
      vecs.push_back(mk("SLT",      6'h02, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 1));
      vecs.push_back(mk("SLTU",     6'h03, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1));
      vecs.push_back(mk("XOR",      6'h04, 32'hF0F0,     32'hFF00,     32'h0FF0,     0, 1));
      vecs.push_back(mk("SRL",      6'h05, 32'h80000000, 32'h4,        32'h08000000, 0, 1));
      vecs.push_back(mk("OR",       6'h06, 32'hF0,       32'h0F,       32'hFF,       0, 1));
      vecs.push_back(mk("AND",      6'h07, 32'hF0F0,     32'hFF00,     32'hF000,     0, 1));
      vecs.push_back(mk("SRA",      6'h0D, 32'h80000000, 32'h24,       32'hF8000000, 0, 1));
      vecs.push_back(mk("B1 illeg", 6'h09, 32'h5,        32'h3,        32'h0,        0, 1));
      vecs.push_back(mk("BEQ",      6'h10, 32'h3,        32'h3,        32'h1,        1, 1));
      vecs.push_back(mk("BNE",      6'h11, 32'h3,        32'h3,        32'h0,        0, 1));
      vecs.push_back(mk("BLT",      6'h14, 32'hFFFFFFFF, 32'h1,        32'h1,        1, 1));
      vecs.push_back(mk("BGE",      6'h15, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1));
      vecs.push_back(mk("BLTU",     6'h16, 32'h1,        32'hFFFFFFFF, 32'h1,        1, 1));
      vecs.push_back(mk("BGEU",     6'h17, 32'h1,        32'hFFFFFFFF, 32'h0,        0, 1));
      vecs.push_back(mk("PASS",     6'h18, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 1));
      vecs.push_back(mk("MUL",      6'h20, 32'h7FFFFFFF, 32'h2,        32'hFFFFFFFE, 0, 34));
      vecs.push_back(mk("MULH",     6'h21, 32'h7FFFFFFF, 32'h2,        32'h0,        0, 34));
      vecs.push_back(mk("MULHU",    6'h23, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 34));
      vecs.push_back(mk("MULHSU",   6'h22, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0, 34));
      vecs.push_back(mk("MULH neg", 6'h21, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 0, 34));
      vecs.push_back(mk("MUL neg",  6'h20, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFF1, 0, 34));
      vecs.push_back(mk("MULHU 2",  6'h23, 32'hFFFFFFFD, 32'h5,        32'h4,        0, 34));
      vecs.push_back(mk("DIV",      6'h24, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 0, 34));
      vecs.push_back(mk("REM",      6'h26, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 0, 34));
      vecs.push_back(mk("DIVU",     6'h25, 32'd100,      32'd7,        32'd14,       0, 34));
      vecs.push_back(mk("REMU",     6'h27, 32'd100,      32'd7,        32'd2,        0, 34));
      vecs.push_back(mk("DIV nb",   6'h24, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 34));
      vecs.push_back(mk("REM nb",   6'h26, 32'h7,        32'hFFFFFFFE, 32'h1,        0, 34));
      vecs.push_back(mk("DIVU big", 6'h25, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 34));
      vecs.push_back(mk("DIVU /0",  6'h25, 32'h1234,     32'h0,        32'hFFFFFFFF, 0, 2));
      vecs.push_back(mk("REMU /0",  6'h27, 32'h1234,     32'h0,        32'h1234,     0, 2));
      vecs.push_back(mk("DIV /0",   6'h24, 32'h5,        32'h0,        32'hFFFFFFFF, 0, 2));
      vecs.push_back(mk("REM ovf",  6'h26, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 2));
      vecs.push_back(mk("DIV ovf",  6'h24, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 2));

      foreach (vecs[i]) run_vec(vecs[i]);

      // ---- back-to-back ADDs: one result per cycle ----
      alu_control = 6'h00;
      for (int i = 0; i < 4; i++) begin
         operand_a = 32'(i * 3);
         operand_b = 32'd10;
         in_valid  = 1'b1;
         @(negedge clock);
         chk($sformatf("b2b %0d out_valid", i), out_valid, 1);
         chk($sformatf("b2b %0d result", i), alu_result, 32'(i * 3 + 10));
      end
      in_valid = 1'b0;
      @(negedge clock);
      chk("b2b drained", out_valid, 0);

      // ---- hold under backpressure ----
      out_ready   = 1'b0;
      alu_control = 6'h16;
      operand_a   = 32'h1;
      operand_b   = 32'hFFFFFFFF;
      in_valid    = 1'b1;
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      operand_a = 32'hFFFFFFFF;
      operand_b = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk($sformatf("hold %0d out_valid", i), out_valid, 1);
         chk($sformatf("hold %0d result", i), alu_result, 1);
         chk($sformatf("hold %0d branch", i), branch, 1);
         chk($sformatf("hold %0d in_ready", i), in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clock);
      chk("release out_valid", out_valid, 0);
      chk("release in_ready", in_ready, 1);

      // ---- async reset in the middle of CALC ----
      alu_control = 6'h20;
      operand_a   = 32'h1234;
      operand_b   = 32'h10;
      in_valid    = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      repeat (11) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async reset out_valid", out_valid, 0);
      chk("async reset result", alu_result, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("post reset in_ready", in_ready, 1);

      // ---- flush in the middle of CALC ----
      alu_control = 6'h25;
      operand_a   = 32'd100;
      operand_b   = 32'd7;
      in_valid    = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      repeat (11) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      chk("flush in_ready", in_ready, 1);
      chk("flush out_valid", out_valid, 0);
      stray = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (out_valid) stray = 1'b1;
      end
      chk("no result after flush", stray, 0);
      run_vec(mk("ADD after flush", 6'h00, 32'd10, 32'd20, 32'd30, 0, 1));
      run_vec(mk("MUL after flush", 6'h20, 32'd3,  32'd4,  32'd12, 0, 34));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, handshaked successor to the core's single-cycle integer ALU.
- Executes the base ALU blocks (add/logic/shift, sub/arith-shift, branch compare, pass-through) with 1-cycle registered latency.
- Adds RV32M/RV64M multiply/divide through an iterative radix-2 engine.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous abort of the in-flight op
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- alu_control  in  6  [5]=M-ext select, [4:3]=block, [2:0]=funct3
- operand_a  in  XLEN  source A
- operand_b  in  XLEN  source B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- alu_result  out  XLEN  result
- branch  out  1  branch taken (block 2 only)

Behaviour:
- Reset (async): state=IDLE; out_valid=0, alu_result=0, branch=0. in_ready=1 after reset deasserts.
- States: IDLE, PREP, CALC, DONE.
- Accept occurs when in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Back-to-back base ops therefore sustain 1 op/cycle.
- Base op (alu_control[5]=0): accept -> DONE. out_valid=1 on the next cycle.
- Base-op function per block (funct3 semantics are core-standard):
  - Block 0: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - Block 1: SUB, SRA (funct3 101); other funct3 return 0.
  - Block 2: BEQ/BNE/BLT/BGE/BLTU/BGEU; alu_result = {0, cmp}, branch = cmp.
  - Block 3: alu_result = operand_a.
  - branch = 0 outside block 2.
- Shifts use only operand_b[SHW-1:0]. Left shift is always logical.
- M op (alu_control[5]=1; funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU):
  - Accept -> PREP (1 cycle): capture operand signs, take absolute values per signedness, detect special cases.
  - PREP -> CALC: XLEN cycles, one bit per cycle.
  - Multiply: shift-add, 2*XLEN product.
  - Divide: restoring shift-subtract.
  - CALC -> DONE: final sign correction, result registered.
  - out_valid rises XLEN+2 cycles after the accept edge (34 for XLEN=32).
- Special cases resolved in PREP; PREP -> DONE directly, out_valid 2 cycles after accept:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (MIN / -1): DIV = MIN; REM = 0.
- DONE: alu_result and branch are held stable while out_valid && !out_ready.
  - out_ready=1 with no new accept -> IDLE, out_valid=0.
- Sign rules:
  - MULH: signed x signed, upper XLEN bits.
  - MULHSU: signed A x unsigned B.
  - MULHU: unsigned x unsigned.
  - MUL: lower XLEN bits.
  - Quotient sign = sA^sB; remainder sign = sA.
- flush (sync, priority over all except reset): -> IDLE, out_valid=0, no accept that cycle, iteration counter cleared.
- Illegal block-1 funct3 with alu_control[5]=0: returns 0, 1-cycle latency, no error flag.
- Inputs are sampled only on the accept edge; later changes to operands are ignored.

Decomposition:
- Shared package alu_pkg holds:
  - funct3 localparams (ALU and branch sets) and M-ext funct3 codes.
  - Block encodings (BLOCK0..3).
  - State enum (IDLE/PREP/CALC/DONE).
- Sub-module alu_muldiv_seq: iterative multiply/divide datapath.
  - Ports: start, op, abs operands, signs → done, result.
  - Counter of SHW+1 bits.
  - alu_iter owns the FSM, handshake and base-op combinational logic.

Test Plan:
- ADD 5 + 0xFFFFFFFD, accept at cycle 0 -> out_valid at cycle 1, alu_result=0x00000002, branch=0. Repeat with out_ready=1 every cycle -> one result per cycle.
- MUL 0x7FFFFFFF*2 -> 0xFFFFFFFE at cycle 34. MULH same operands -> 0x00000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. in_ready=0 during cycles 1-34.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100/7 -> 14, REMU -> 2. All at cycle 34.
- DIVU 0x1234/0 -> 0xFFFFFFFF at cycle 2. REM 0x80000000 / 0xFFFFFFFF -> 0x00000000 at cycle 2. DIV same -> 0x80000000.
- BLTU 1 vs 0xFFFFFFFF -> branch=1, alu_result=1. Hold out_ready=0 for 5 cycles -> result, branch and out_valid stable, in_ready=0. Release -> IDLE.
- Assert reset at CALC cycle 10 -> out_valid=0 and alu_result=0 immediately (async). Separately, flush at CALC cycle 10 -> IDLE next cycle; a subsequent ADD completes correctly.
